// File: rtl/spike_rate_decoder_pkg.sv
// Shared definitions for the spike receive path: FSM states, defaults, saturating add.
package spike_rate_decoder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam logic [7:0] DEF_WINDOW      = 8'd64;
  localparam logic [7:0] DEF_WEIGHT      = 8'd32;
  localparam int         DEF_DECAY_SHIFT = 1;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/spike_rate_decoder_synapse_trace.sv
// Synaptic current trace: exponential decay plus WEIGHT per spike, clamped at 255.
// One cycle from spike_i sample to current_o; free running, never stalls.
module synapse_trace
  import spike_rate_decoder_pkg::*;
#(
  parameter logic [7:0] WEIGHT      = DEF_WEIGHT,
  parameter int         DECAY_SHIFT = DEF_DECAY_SHIFT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spike_i,
  output logic [7:0] current_o
);

  logic [7:0] cur_q, cur_d;

  always_comb begin
    cur_d = sat_add8(cur_q >> DECAY_SHIFT, spike_i ? WEIGHT : 8'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cur_q <= 8'd0;
    else         cur_q <= cur_d;
  end

  assign current_o = cur_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train to magnitudes: current trace plus windowed spike count offered via valid/ready.
// Rate result registered at window end; a result arriving while one is still pending is dropped (overrun pulse).
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter logic [7:0] WINDOW      = DEF_WINDOW,
  parameter logic [7:0] WEIGHT      = DEF_WEIGHT,
  parameter int         DECAY_SHIFT = DEF_DECAY_SHIFT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       spike_i,
  output logic [7:0] current_o,
  output logic [7:0] rate_o,
  output logic       rate_valid_o,
  input  logic       rate_ready_i,
  output logic       overrun_o
);

  localparam logic [7:0] LAST = WINDOW - 8'd1;

  state_e     state_q;
  logic [7:0] win_cnt_q, spk_cnt_q;
  logic [7:0] rate_q;
  logic       rate_valid_q, overrun_q;

  synapse_trace #(
    .WEIGHT      (WEIGHT),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_trace (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .spike_i   (spike_i),
    .current_o (current_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      win_cnt_q    <= 8'd0;
      spk_cnt_q    <= 8'd0;
      rate_q       <= 8'd0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      // A transfer clears valid unless a fresh result loads on this same edge (below).
      if (rate_valid_q && rate_ready_i) rate_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          win_cnt_q <= 8'd0;
          spk_cnt_q <= 8'd0;
          if (en_i) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          if (!en_i) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= 8'd0;
            spk_cnt_q <= 8'd0;
          end else if (win_cnt_q == LAST) begin
            win_cnt_q <= 8'd0;
            spk_cnt_q <= 8'd0;
            if (!rate_valid_q || rate_ready_i) begin
              rate_q       <= spk_cnt_q + {7'd0, spike_i};
              rate_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            win_cnt_q <= win_cnt_q + 8'd1;
            spk_cnt_q <= spk_cnt_q + {7'd0, spike_i};
          end
        end
      endcase
    end
  end

  assign rate_o       = rate_q;
  assign rate_valid_o = rate_valid_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: two instances (WEIGHT 32 and 200, WINDOW 8) checked
// against a queue-based model every cycle, plus literal expectations for the key sequences.
module tb_spike_rate_decoder;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, spk_a = 1'b0, spk_b = 1'b0, rdy = 1'b0;
  logic       en_b = 1'b0, rdy_b = 1'b1;
  logic [7:0] cur_a, rate_a, cur_b, rate_b;
  logic       vld_a, ovr_a, vld_b, ovr_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int  m_cur_a = 0, m_cur_b = 0, m_rate = 0;
  bit  m_busy = 0, m_vld = 0, m_ovr = 0;
  int  win_q[$];

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(8'd8), .WEIGHT(8'd32), .DECAY_SHIFT(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .spike_i(spk_a),
    .current_o(cur_a), .rate_o(rate_a), .rate_valid_o(vld_a),
    .rate_ready_i(rdy), .overrun_o(ovr_a)
  );

  spike_rate_decoder #(.WINDOW(8'd8), .WEIGHT(8'd200), .DECAY_SHIFT(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .spike_i(spk_b),
    .current_o(cur_b), .rate_o(rate_b), .rate_valid_o(vld_b),
    .rate_ready_i(rdy_b), .overrun_o(ovr_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int trace(input int cur, input bit spk, input int wgt);
    int s;
    s = cur / 2 + (spk ? wgt : 0);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic model_reset();
    m_cur_a = 0; m_cur_b = 0; m_rate = 0;
    m_busy = 0; m_vld = 0; m_ovr = 0;
    win_q.delete();
  endtask

  // Applies the behavioural rules for one rising edge using the inputs held across it.
  task automatic model_step();
    bit xfer, loaded;
    int res;
    xfer    = m_vld && rdy;
    loaded  = 0;
    m_cur_a = trace(m_cur_a, spk_a, 32);
    m_cur_b = trace(m_cur_b, spk_b, 200);
    m_ovr   = 0;
    if (!m_busy) begin
      if (en) m_busy = 1;
    end else if (!en) begin
      m_busy = 0;
      win_q.delete();
    end else begin
      win_q.push_back(int'(spk_a));
      if (win_q.size() == W) begin
        res = win_q.sum();
        win_q.delete();
        if (!m_vld || rdy) begin
          m_rate = res; m_vld = 1; loaded = 1;
        end else begin
          m_ovr = 1;
        end
      end
    end
    if (xfer && !loaded) m_vld = 0;
  endtask

  task automatic cyc(input bit e, input bit sa, input bit sb, input bit r);
    en = e; spk_a = sa; spk_b = sb; rdy = r;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cur_a", cur_a, m_cur_a);
    chk("cur_b", cur_b, m_cur_b);
    chk("rate_valid", vld_a, m_vld);
    chk("overrun", ovr_a, m_ovr);
    if (m_vld) chk("rate", rate_a, m_rate);
    chk("b_valid", vld_b, 0);
    chk("b_overrun", ovr_b, 0);
  end

  initial begin
    int seq3[6];
    seq3 = '{16, 8, 4, 2, 1, 0};
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_cur", cur_a, 0);
    chk("reset_vld", vld_a, 0);
    chk("reset_rate", rate_a, 0);
    rst_n = 1'b1;

    // Single spike decay
    cyc(0, 1, 0, 1);
    chk("t3_first", cur_a, 32);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1);
      chk("t3_decay", cur_a, seq3[i]);
    end

    // Saturation on the heavy-weight instance
    cyc(0, 0, 1, 1); chk("t4_200", cur_b, 200);
    cyc(0, 0, 1, 1); chk("t4_sat", cur_b, 255);
    cyc(0, 0, 1, 1); chk("t4_hold", cur_b, 255);
    cyc(0, 0, 0, 1); chk("t4_127", cur_b, 127);
    cyc(0, 0, 0, 1); chk("t4_63", cur_b, 63);

    // Back-to-back full windows, consumer always ready
    cyc(1, 1, 0, 1);
    chk("t2_enter", vld_a, 0);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < W; i++) begin
        cyc(1, 1, 0, 1);
        if (i < W - 1) chk("t2_novld", vld_a, 0);
      end
      chk("t2_vld", vld_a, 1);
      chk("t2_rate", rate_a, 8);
    end
    cyc(0, 0, 0, 1);
    chk("t2_drop", vld_a, 0);

    // Consumer stalled across two windows: 3 then 5 spikes
    cyc(1, 0, 0, 0);
    for (int i = 0; i < W; i++) cyc(1, i < 3, 0, 0);
    chk("t5_rate1", rate_a, 3);
    for (int i = 0; i < W; i++) begin
      cyc(1, i < 5, 0, 0);
      if (i < W - 1) chk("t5_noovr", ovr_a, 0);
    end
    chk("t5_ovr", ovr_a, 1);
    chk("t5_keep", rate_a, 3);
    cyc(0, 0, 0, 0);
    chk("t5_ovr_end", ovr_a, 0);
    chk("t5_pending", vld_a, 1);
    cyc(0, 0, 0, 1);
    chk("t5_xfer", vld_a, 0);

    // Partial window aborted by en_i, then one clean window with 2 spikes
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t6_abort", vld_a, 0);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < W; i++) begin
      cyc(1, i == 2 || i == 6, 0, 1);
      chk("t6_noovr", ovr_a, 0);
    end
    chk("t6_vld", vld_a, 1);
    chk("t6_rate", rate_a, 2);
    cyc(0, 0, 0, 1);

    // Async reset mid-window with a pending result and current at 200
    cyc(1, 0, 0, 0);
    for (int i = 0; i < W; i++) cyc(1, i[0], 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    chk("t1_pre_vld", vld_a, 1);
    chk("t1_pre_cur", cur_b, 200);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_async_vld", vld_a, 0);
    chk("t1_async_rate", rate_a, 0);
    chk("t1_async_cur", cur_b, 0);
    chk("t1_async_ovr", ovr_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) cyc(0, 0, 0, 1);
    chk("t1_after_vld", vld_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
